// File: rtl/stack_controller.sv
// Hardware stack sequencer: owns SP and depth, turns push/pop/peek/load
// commands into single-word accesses on the shared data memory port.
// The stack grows downward and SP always names the next free word.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; overflow/underflow judged here
// WR    | push write in flight, strobe held until mem_ack
// RD    | pop/peek read of sp+1 in flight, strobe held until mem_ack
// RESP  | one-cycle completion pulse carrying rsp_err/rsp_data
module stack_controller #(
   parameter int N = 9,
   parameter int W = 16,
   parameter logic [N-1:0] SP_INIT = {N{1'b1}}
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_data,
   output logic         rsp_valid,
   output logic         rsp_err,
   output logic [W-1:0] rsp_data,
   output logic [N-1:0] mem_addr,
   output logic [W-1:0] mem_wdata,
   output logic         mem_we,
   output logic         mem_re,
   input  logic [W-1:0] mem_rdata,
   input  logic         mem_ack,
   output logic [N-1:0] sp,
   output logic [N:0]   depth,
   output logic         full,
   output logic         empty
);

   typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

   localparam logic [1:0]   OP_PUSH   = 2'b00;
   localparam logic [1:0]   OP_POP    = 2'b01;
   localparam logic [1:0]   OP_PEEK   = 2'b10;
   localparam logic [1:0]   OP_LOAD   = 2'b11;
   localparam logic [N-1:0] ONE_N     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N:0]   ONE_D     = {{N{1'b0}}, 1'b1};
   localparam logic [N:0]   DEPTH_MAX = {1'b1, {N{1'b0}}};

   state_t         state, state_nxt;
   logic           accept;
   logic           pop_q;
   logic           err_q;
   logic [W-1:0]   wdata_q;
   logic [W-1:0]   rdata_q;
   logic [N-1:0]   sp_plus1;

   assign full     = (depth == DEPTH_MAX);
   assign empty    = (depth == '0);
   assign accept   = cmd_valid && cmd_ready;
   assign sp_plus1 = sp + ONE_N;

   // State register; reset abandons any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and memory/response outputs, all decoded from the state
   // register so that reset drops every strobe without waiting for a clock.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH: state_nxt = full ? RESP : WR;
                  OP_POP:  state_nxt = empty ? RESP : RD;
                  OP_PEEK: state_nxt = empty ? RESP : RD;
                  OP_LOAD: state_nxt = RESP;
               endcase
            end
         end
         WR: begin
            mem_addr  = sp;
            mem_wdata = wdata_q;
            mem_we    = 1'b1;
            if (mem_ack) state_nxt = RESP;
         end
         RD: begin
            mem_addr = sp_plus1;
            mem_re   = 1'b1;
            if (mem_ack) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_data  = rdata_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command capture, SP/depth bookkeeping and read-data latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp      <= SP_INIT;
         depth   <= '0;
         pop_q   <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            pop_q   <= (cmd_op == OP_POP);
            wdata_q <= cmd_data;
            rdata_q <= '0;
            err_q   <= ((cmd_op == OP_PUSH) && full) ||
                       (((cmd_op == OP_POP) || (cmd_op == OP_PEEK)) && empty);
            if (cmd_op == OP_LOAD) begin
               sp    <= cmd_data[N-1:0];
               depth <= '0;
            end
         end
         if ((state == WR) && mem_ack) begin
            sp    <= sp - ONE_N;
            depth <= depth + ONE_D;
         end
         if ((state == RD) && mem_ack) begin
            rdata_q <= mem_rdata;
            if (pop_q) begin
               sp    <= sp_plus1;
               depth <= depth - ONE_D;
            end
         end
      end
   end

endmodule
